// File: rtl/claw_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// claw_ctrl_pkg
// Shared constants for the claw-machine control front end.
//   - Channel index constants for the raw_in / level / rise / fall vectors.
//   - CTRL_ADDR: data-memory word address where the CPU reads the control word.
//   - DEFAULT_DEBOUNCE_CYCLES: 10 ms worth of stable cycles at 100 MHz.
//   - pack_control(): builds the interlocked 32-bit control word from levels.
// ---------------------------------------------------------------------------
package claw_ctrl_pkg;

    localparam int CH_RIGHT = 0;
    localparam int CH_LEFT  = 1;
    localparam int CH_FWD   = 2;
    localparam int CH_BACK  = 3;
    localparam int CH_CLAW  = 4;
    localparam int CH_START = 5;

    localparam int NUM_CHANNELS = 6;

    localparam int CTRL_ADDR = 1000;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // Opposing directions on one axis cancel each other so the stepper
    // drivers never receive a contradictory command. Claw and start are
    // independent and pass straight through.
    function automatic logic [31:0] pack_control(input logic [NUM_CHANNELS-1:0] lv);
        logic [31:0] word;
        logic        lr_conflict;
        logic        fb_conflict;
        word        = '0;
        lr_conflict = lv[CH_RIGHT] & lv[CH_LEFT];
        fb_conflict = lv[CH_FWD] & lv[CH_BACK];
        word[CH_RIGHT] = lv[CH_RIGHT] & ~lr_conflict;
        word[CH_LEFT]  = lv[CH_LEFT]  & ~lr_conflict;
        word[CH_FWD]   = lv[CH_FWD]   & ~fb_conflict;
        word[CH_BACK]  = lv[CH_BACK]  & ~fb_conflict;
        word[CH_CLAW]  = lv[CH_CLAW];
        word[CH_START] = lv[CH_START];
        return word;
    endfunction

endpackage

// File: rtl/joystick_input_conditioner_debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One input channel: 2-flop synchronizer, stable-count debouncer, level
// register and registered rise/fall pulses.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   raw        in   asynchronous pin level
//   level      out  debounced level
//   rise       out  one-cycle pulse on a debounced 0->1 transition
//   fall       out  one-cycle pulse on a debounced 1->0 transition
//   level_next out  combinational next-state of level (feeds the top's
//                   control-word register so it updates with level)
// ---------------------------------------------------------------------------
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic level_next
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    // Any cycle where the synchronized input agrees with level restarts the
    // count, so only an uninterrupted disagreement of DEBOUNCE_CYCLES cycles
    // flips the level. The counter therefore never passes LAST_COUNT.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; without them
        // the missing else-branches would infer latches.
        level_next = level;
        count_next = '0;
        if (sync2 != level) begin
            if (count == LAST_COUNT) begin
                level_next = ~level;
            end else begin
                count_next = count + 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments make sync2 take the old sync1, giving a
    // real two-stage chain; blocking ones would collapse it into one flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            count <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            count <= count_next;
            level <= level_next;
            rise  <= level_next & ~level;
            fall  <= ~level_next & level;
        end
    end

endmodule

// File: rtl/joystick_input_conditioner.sv
// ---------------------------------------------------------------------------
// joystick_input_conditioner
// Synchronizes and debounces the joystick, claw and start pins, produces edge
// pulses, and packs the clean levels into the control word the CPU reads at
// data-memory address CTRL_ADDR.
// Ports:
//   CLK100MHZ    in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   raw_in       in   [0] right [1] left [2] forward [3] backward
//                     [4] claw drop [5] start game (asynchronous levels)
//   level        out  debounced levels, same mapping
//   rise         out  per-channel one-cycle 0->1 pulse
//   fall         out  per-channel one-cycle 1->0 pulse
//   control_bits out  interlocked control word, [31:6] always 0
//   ctrl_update  out  one-cycle pulse whenever any level bit changes
// ---------------------------------------------------------------------------
module joystick_input_conditioner
    import claw_ctrl_pkg::*;
#(
    parameter int N_IN            = NUM_CHANNELS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20
) (
    input  logic            CLK100MHZ,
    input  logic            reset,
    input  logic [N_IN-1:0] raw_in,
    output logic [N_IN-1:0] level,
    output logic [N_IN-1:0] rise,
    output logic [N_IN-1:0] fall,
    output logic [31:0]     control_bits,
    output logic            ctrl_update
);

    logic [N_IN-1:0] level_next;

    for (genvar i = 0; i < N_IN; i++) begin : g_channel
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_channel (
            .clk       (CLK100MHZ),
            .reset     (reset),
            .raw       (raw_in[i]),
            .level     (level[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .level_next(level_next[i])
        );
    end

    // Built from next-state levels so the word and ctrl_update land on the
    // same edge as level/rise/fall; several channels changing together
    // still produce a single update pulse.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            control_bits <= '0;
            ctrl_update  <= 1'b0;
        end else begin
            control_bits <= pack_control(level_next);
            ctrl_update  <= |(level_next ^ level);
        end
    end

endmodule

// File: doc/joystick_input_conditioner.md
Name: joystick_input_conditioner

Overview:
Upstream front end for the claw-machine controls. Takes the raw joystick, claw and start pin levels, synchronizes and debounces each one, and generates edge pulses. It then packs the clean levels into the 32-bit control word that the CPU reads from data memory at address 1000. This replaces the direct pin-to-RAM path, so the CPU and the stepper/servo drivers never see metastable or bouncing inputs.

Parameters:
N_IN, 6, number of conditioned input channels (fixed mapping below; must be 6)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz); must be >= 2
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
CLK100MHZ  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
raw_in  input  6  asynchronous pin levels: [0] right, [1] left, [2] forward, [3] backward, [4] claw drop, [5] start game
level  output  6  debounced, synchronized levels, same bit mapping
rise  output  6  one-cycle pulse per channel on a debounced 0->1 transition
fall  output  6  one-cycle pulse per channel on a debounced 1->0 transition
control_bits  output  32  packed control word for the RAM write at address 1000
ctrl_update  output  1  one-cycle pulse when any level bit changes

Behaviour:
- One clock domain and one reset. Reset is synchronous and active-high, with clock port CLK100MHZ and reset port reset.
- Reset state: sync flops, counters, level, rise, fall, control_bits and ctrl_update are all 0 on the first edge where reset=1. Outputs hold 0 while reset stays high.
- Synchronizer: each channel uses a 2-flop chain, sync1 <= raw_in, then sync2 <= sync1. No other logic touches raw_in.
- Debounce, per channel, evaluated each edge:
  - If sync2 == level: the counter clears to 0.
  - Else, if counter == DEBOUNCE_CYCLES-1: level flips and the counter clears.
  - Else: the counter increments.
- A glitch shorter than DEBOUNCE_CYCLES therefore never changes level, and any return to the old value restarts the count.
- Latency: suppose raw_in first holds its new value at rising edge k and stays stable. level then changes at edge k+1+DEBOUNCE_CYCLES. It is visible after that edge, i.e. DEBOUNCE_CYCLES+2 edges counting edge k.
- rise/fall are registered:
  - Each asserts for exactly one cycle, on the same cycle level first shows the new value.
  - rise and fall are never asserted together on one channel.
  - A channel cannot pulse again sooner than DEBOUNCE_CYCLES cycles later.
- ctrl_update is the OR of all rise|fall bits, so it is one cycle long. Simultaneous changes on several channels produce a single pulse.
- control_bits is registered, updated on the same edge as level, and computed from the next-state level:
  - [0] right and [1] left are both forced to 0 if right and left are both 1 (axis interlock).
  - [2] forward and [3] backward are both forced to 0 if forward and backward are both 1.
  - [4] claw and [5] start pass through unchanged.
  - [31:6] are always 0.
- Raw level outputs are not interlocked; only control_bits is.
- Reset mid-count: the counter is discarded. After reset falls, a held input needs the full latency again, measured from the first post-reset edge.
- No saturation or wrap: the counter never exceeds DEBOUNCE_CYCLES-1.

Decomposition:
- Package claw_ctrl_pkg:
  - Channel index constants CH_RIGHT=0, CH_LEFT=1, CH_FWD=2, CH_BACK=3, CH_CLAW=4, CH_START=5.
  - CTRL_ADDR=1000.
  - Default DEBOUNCE_CYCLES.
- One sub-module, debounce_channel, holds one channel's synchronizer, counter, level register and rise/fall registers. The top generates 6 instances and adds the interlock/pack logic and ctrl_update.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
1. Hold reset=1 for 3 edges with raw_in=6'h3F -> level=0, rise=0, fall=0, control_bits=0, ctrl_update=0 on every cycle.
2. raw_in[2] 0->1 at edge k, held -> level[2]=1 after edge k+5. rise[2] and ctrl_update are high for that one cycle only. control_bits=32'h4.
3. raw_in[4] high for 3 cycles, then low -> level, rise, ctrl_update and control_bits never change.
4. raw_in[2] and raw_in[3] both held high -> level[3:2]=2'b11 and control_bits[3:2]=0. Then release raw_in[3] -> after 6 edges control_bits=32'h4 and fall[3] pulses once.
5. raw_in[0] high, reset pulsed for 1 cycle at count 2 -> all outputs 0. level[0] rises exactly 6 edges after reset deasserts.
6. With level=6'h04, at the same edge raw_in becomes 6'h10 -> rise[4] and fall[2] in the same cycle, a single ctrl_update pulse, control_bits=32'h10.
